// File: rtl/pc_fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package pc_fetch_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FULL  = 1'b1
    } pf_state_t;

    localparam int PF_ADDR_W_DEF      = 16;
    localparam int PF_DATA_W_DEF      = 16;
    localparam int PF_RESET_VEC_DEF   = 0;
    localparam int PF_WAIT_STATES_DEF = 1;
    localparam int PF_WCNT_W          = 4;

endpackage

// File: rtl/pc_fetch_wait_cnt.sv
// RAM2 wait-state counter: counts up from 0 and flags when it reaches WAIT_STATES.
module pf_wait_cnt
    import pc_fetch_pkg::*;
#(
    parameter int WAIT_STATES = PF_WAIT_STATES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [PF_WCNT_W-1:0] TC_VAL = PF_WCNT_W'(WAIT_STATES);

    logic [PF_WCNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + PF_WCNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: reads RAM2 at the PC, buffers one instruction for decode.
//   state    | meaning
//   ST_FETCH | RAM2 read in progress (oe low), wait counter running
//   ST_FULL  | instruction buffered, no read in progress (oe high)
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W      = PF_ADDR_W_DEF,
    parameter int                DATA_W      = PF_DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(PF_RESET_VEC_DEF),
    parameter int                WAIT_STATES = PF_WAIT_STATES_DEF
) (
    input  logic              pfi_clk,
    input  logic              pfi_rst,
    input  logic              pfi_en,
    input  logic              pfi_interrupt,
    input  logic [ADDR_W-1:0] pfi_epc,
    input  logic              pfi_branch,
    input  logic [ADDR_W-1:0] pfi_new_addr,
    input  logic              pfi_ready,
    input  logic [DATA_W-1:0] pfi_ram2_data,
    output logic [ADDR_W-1:0] pfo_ram2_addr,
    output logic              pfo_ram2_oe,
    output logic              pfo_valid,
    output logic [DATA_W-1:0] pfo_instr,
    output logic [ADDR_W-1:0] pfo_instr_pc
);

    pf_state_t         r_state;
    pf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [DATA_W-1:0] r_instr;
    logic              r_oe;
    logic              w_capture;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_tc;

    pf_wait_cnt #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait_cnt (
        .i_clk  (pfi_clk),
        .i_rst_n(pfi_rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_tc   (w_tc)
    );

    always_ff @(posedge pfi_clk) begin
        if (!pfi_rst) begin
            r_state <= ST_FETCH;
        end else if (pfi_en) begin
            r_state <= w_state_nxt;
        end
    end

    // FETCH with oe still high is the idle cycle right after reset: it starts the read.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        if (pfi_en) begin
            if (pfi_interrupt) begin
                w_pc_nxt    = pfi_epc;
                w_state_nxt = ST_FETCH;
                w_cnt_clr   = 1'b1;
            end else if (pfi_branch) begin
                w_pc_nxt    = pfi_new_addr;
                w_state_nxt = ST_FETCH;
                w_cnt_clr   = 1'b1;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (!r_oe) begin
                            if (w_tc) begin
                                w_capture   = 1'b1;
                                w_pc_nxt    = r_pc + ADDR_W'(1);
                                w_state_nxt = ST_FULL;
                                w_cnt_clr   = 1'b1;
                            end else begin
                                w_cnt_en = 1'b1;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (pfi_ready) begin
                            w_state_nxt = ST_FETCH;
                            w_cnt_clr   = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_FETCH;
                        w_cnt_clr   = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge pfi_clk) begin
        if (!pfi_rst) begin
            r_pc       <= RESET_VEC;
            r_oe       <= 1'b1;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (pfi_en) begin
            r_pc <= w_pc_nxt;
            r_oe <= (w_state_nxt == ST_FULL);
            if (w_capture) begin
                r_instr    <= pfi_ram2_data;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign pfo_ram2_addr = r_pc;
    assign pfo_ram2_oe   = r_oe;
    assign pfo_valid     = (r_state == ST_FULL);
    assign pfo_instr     = r_instr;
    assign pfo_instr_pc  = r_instr_pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: three instances (WAIT_STATES 1/0/3) share stimulus;
// directed vector table, corner sequences, then random traffic against a cycle model.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        pf_rst = 1'b0;
    logic        pf_en = 1'b1;
    logic        pf_irq = 1'b0;
    logic        pf_br = 1'b0;
    logic        pf_rdy = 1'b0;
    logic [15:0] pf_epc = 16'h0;
    logic [15:0] pf_naddr = 16'h0;
    logic [15:0] tb_data = 16'h0;
    bit          ram_mode = 1'b0;

    logic [15:0] addr_o [3];
    logic        oe_o   [3];
    logic        val_o  [3];
    logic [15:0] ins_o  [3];
    logic [15:0] ipc_o  [3];
    logic [15:0] rdata  [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] fdat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    assign rdata[0] = ram_mode ? fdat(addr_o[0]) : tb_data;
    assign rdata[1] = ram_mode ? fdat(addr_o[1]) : tb_data;
    assign rdata[2] = ram_mode ? fdat(addr_o[2]) : tb_data;

    pc_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_VEC(16'h0100), .WAIT_STATES(1)) u_dut0 (
        .pfi_clk(clk), .pfi_rst(pf_rst), .pfi_en(pf_en), .pfi_interrupt(pf_irq),
        .pfi_epc(pf_epc), .pfi_branch(pf_br), .pfi_new_addr(pf_naddr), .pfi_ready(pf_rdy),
        .pfi_ram2_data(rdata[0]), .pfo_ram2_addr(addr_o[0]), .pfo_ram2_oe(oe_o[0]),
        .pfo_valid(val_o[0]), .pfo_instr(ins_o[0]), .pfo_instr_pc(ipc_o[0]));

    pc_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_VEC(16'h0000), .WAIT_STATES(0)) u_dut1 (
        .pfi_clk(clk), .pfi_rst(pf_rst), .pfi_en(pf_en), .pfi_interrupt(pf_irq),
        .pfi_epc(pf_epc), .pfi_branch(pf_br), .pfi_new_addr(pf_naddr), .pfi_ready(pf_rdy),
        .pfi_ram2_data(rdata[1]), .pfo_ram2_addr(addr_o[1]), .pfo_ram2_oe(oe_o[1]),
        .pfo_valid(val_o[1]), .pfo_instr(ins_o[1]), .pfo_instr_pc(ipc_o[1]));

    pc_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_VEC(16'h0000), .WAIT_STATES(3)) u_dut2 (
        .pfi_clk(clk), .pfi_rst(pf_rst), .pfi_en(pf_en), .pfi_interrupt(pf_irq),
        .pfi_epc(pf_epc), .pfi_branch(pf_br), .pfi_new_addr(pf_naddr), .pfi_ready(pf_rdy),
        .pfi_ram2_data(rdata[2]), .pfo_ram2_addr(addr_o[2]), .pfo_ram2_oe(oe_o[2]),
        .pfo_valid(val_o[2]), .pfo_instr(ins_o[2]), .pfo_instr_pc(ipc_o[2]));

    // Reference model: a fetch is "age" elapsed read cycles; it completes at WAIT_STATES+1.
    int          m_ws [3] = '{1, 0, 3};
    logic [15:0] m_rv [3] = '{16'h0100, 16'h0000, 16'h0000};
    logic [15:0] m_pc    [3];
    logic [15:0] m_instr [3];
    logic [15:0] m_ipc   [3];
    bit          m_valid [3];
    bit          m_oe    [3];
    bit          m_started [3];
    int          m_age   [3];

    function automatic logic [49:0] pk(input logic [15:0] a, input logic oe, input logic v,
                                       input logic [15:0] ins, input logic [15:0] ipc);
        return {a, oe, v, ins, ipc};
    endfunction

    function automatic logic [49:0] dut_out(input int i);
        return pk(addr_o[i], oe_o[i], val_o[i], ins_o[i], ipc_o[i]);
    endfunction

    function automatic logic [49:0] model_out(input int i);
        return pk(m_pc[i], m_oe[i], m_valid[i], m_instr[i], m_ipc[i]);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!pf_rst) begin
                m_pc[i] = m_rv[i];
                m_instr[i] = 16'h0;
                m_ipc[i] = 16'h0;
                m_valid[i] = 1'b0;
                m_oe[i] = 1'b1;
                m_started[i] = 1'b0;
                m_age[i] = 0;
            end else if (pf_en) begin
                if (pf_irq || pf_br) begin
                    m_pc[i] = pf_irq ? pf_epc : pf_naddr;
                    m_valid[i] = 1'b0;
                    m_oe[i] = 1'b0;
                    m_age[i] = 0;
                    m_started[i] = 1'b1;
                end else if (m_valid[i]) begin
                    if (pf_rdy) begin
                        m_valid[i] = 1'b0;
                        m_oe[i] = 1'b0;
                        m_age[i] = 0;
                    end
                end else if (!m_started[i]) begin
                    m_started[i] = 1'b1;
                    m_oe[i] = 1'b0;
                end else begin
                    m_age[i] = m_age[i] + 1;
                    if (m_age[i] == m_ws[i] + 1) begin
                        m_instr[i] = ram_mode ? fdat(m_pc[i]) : tb_data;
                        m_ipc[i] = m_pc[i];
                        m_pc[i] = m_pc[i] + 16'd1;
                        m_valid[i] = 1'b1;
                        m_oe[i] = 1'b1;
                        m_age[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [49:0] act, input logic [49:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, en, irq, br, rdy;
        logic [15:0] epc, naddr, data;
        logic [49:0] exp;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic en, input logic irq,
                                 input logic br, input logic rdy, input logic [15:0] epc,
                                 input logic [15:0] naddr, input logic [15:0] data,
                                 input logic [49:0] exp);
        vec_t v;
        v.rst = rst; v.en = en; v.irq = irq; v.br = br; v.rdy = rdy;
        v.epc = epc; v.naddr = naddr; v.data = data; v.exp = exp;
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        logic [49:0] snap;

        // Vectors checked on instance 0 (WAIT_STATES=1, RESET_VEC=0x0100).
        tbl[0]  = mkv(0, 1, 0, 0, 0, 16'h0,    16'h0,    16'h0,    pk(16'h0100, 1, 0, 16'h0,    16'h0));
        tbl[1]  = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'hA5A5, pk(16'h0100, 0, 0, 16'h0,    16'h0));
        tbl[2]  = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'hA5A5, pk(16'h0100, 0, 0, 16'h0,    16'h0));
        tbl[3]  = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'hA5A5, pk(16'h0101, 1, 1, 16'hA5A5, 16'h0100));
        tbl[4]  = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'h1111, pk(16'h0101, 1, 1, 16'hA5A5, 16'h0100));
        tbl[5]  = mkv(1, 1, 0, 0, 1, 16'h0,    16'h0,    16'h1111, pk(16'h0101, 0, 0, 16'hA5A5, 16'h0100));
        tbl[6]  = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'h1234, pk(16'h0101, 0, 0, 16'hA5A5, 16'h0100));
        tbl[7]  = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'h1234, pk(16'h0102, 1, 1, 16'h1234, 16'h0101));
        tbl[8]  = mkv(1, 0, 1, 1, 1, 16'h0040, 16'h3000, 16'h9999, pk(16'h0102, 1, 1, 16'h1234, 16'h0101));
        tbl[9]  = mkv(1, 1, 1, 1, 1, 16'h0040, 16'h3000, 16'h7777, pk(16'h0040, 0, 0, 16'h1234, 16'h0101));
        tbl[10] = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'h7777, pk(16'h0040, 0, 0, 16'h1234, 16'h0101));
        tbl[11] = mkv(1, 1, 0, 0, 0, 16'h0,    16'h0,    16'h7777, pk(16'h0041, 1, 1, 16'h7777, 16'h0040));
        tbl[12] = mkv(0, 1, 0, 0, 0, 16'h0,    16'h0,    16'h7777, pk(16'h0100, 1, 0, 16'h0,    16'h0));

        for (int k = 0; k < 13; k++) begin
            pf_rst = tbl[k].rst; pf_en = tbl[k].en; pf_irq = tbl[k].irq; pf_br = tbl[k].br;
            pf_rdy = tbl[k].rdy; pf_epc = tbl[k].epc; pf_naddr = tbl[k].naddr;
            tb_data = tbl[k].data;
            cycle();
            check($sformatf("vec%0d", k), dut_out(0), tbl[k].exp);
        end

        // Streaming on instance 1 (WAIT_STATES=0): one instruction every second cycle.
        ram_mode = 1'b1;
        pf_rst = 1'b0; pf_en = 1'b1; pf_irq = 1'b0; pf_br = 1'b0; pf_rdy = 1'b1;
        cycle();
        pf_rst = 1'b1;
        cycle();
        check("stream_start", dut_out(1), pk(16'h0000, 0, 0, 16'h0, 16'h0));
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("stream_valid%0d", k), dut_out(1),
                  pk(16'(k + 1), 1, 1, fdat(16'(k)), 16'(k)));
            cycle();
            check($sformatf("stream_gap%0d", k), dut_out(1),
                  pk(16'(k + 1), 0, 0, fdat(16'(k)), 16'(k)));
        end

        // Redirect mid-fetch on instance 2 (WAIT_STATES=3).
        pf_rst = 1'b0; pf_rdy = 1'b0;
        cycle();
        pf_rst = 1'b1;
        cycle();
        cycle();
        pf_br = 1'b1; pf_naddr = 16'h2000;
        cycle();
        pf_br = 1'b0;
        check("redir_edge", dut_out(2), pk(16'h2000, 0, 0, 16'h0, 16'h0));
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("redir_wait%0d", k), dut_out(2), pk(16'h2000, 0, 0, 16'h0, 16'h0));
        end
        cycle();
        check("redir_done", dut_out(2), pk(16'h2001, 1, 1, fdat(16'h2000), 16'h2000));

        // Stall mid-fetch with a branch pulse that must be ignored.
        pf_rdy = 1'b1;
        cycle();
        pf_rdy = 1'b0;
        cycle();
        snap = pk(16'h2001, 0, 0, fdat(16'h2000), 16'h2000);
        check("stall_pre", dut_out(2), snap);
        pf_en = 1'b0; pf_naddr = 16'h5555; pf_rdy = 1'b1;
        for (int s = 0; s < 5; s++) begin
            pf_br = (s == 2);
            cycle();
            check($sformatf("stall_hold%0d", s), dut_out(2), snap);
        end
        pf_en = 1'b1; pf_br = 1'b0; pf_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check($sformatf("stall_resume%0d", k), dut_out(2), snap);
        end
        cycle();
        check("stall_done", dut_out(2), pk(16'h2002, 1, 1, fdat(16'h2001), 16'h2001));

        // PC wrap on instance 1.
        pf_br = 1'b1; pf_naddr = 16'hFFFF; pf_rdy = 1'b0;
        cycle();
        pf_br = 1'b0;
        check("wrap_start", {32'h0, addr_o[1], oe_o[1], val_o[1]}, {32'h0, 16'hFFFF, 1'b0, 1'b0});
        cycle();
        check("wrap_capture", dut_out(1), pk(16'h0000, 1, 1, fdat(16'hFFFF), 16'hFFFF));
        pf_rdy = 1'b1;
        cycle();
        check("wrap_next", dut_out(1), pk(16'h0000, 0, 0, fdat(16'hFFFF), 16'hFFFF));

        // Random traffic on all instances against the model.
        for (int n = 0; n < 600; n++) begin
            pf_rst   = (n == 0 || $urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            pf_en    = ($urandom_range(0, 9) != 0);
            pf_irq   = ($urandom_range(0, 19) == 0);
            pf_br    = ($urandom_range(0, 9) == 0);
            pf_epc   = 16'($urandom);
            pf_naddr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            pf_rdy   = 1'($urandom_range(0, 1));
            cycle();
            for (int i = 0; i < 3; i++)
                check($sformatf("rand%0d_dut%0d", n, i), dut_out(i), model_out(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
